// File: rtl/ws2812b_pkg.sv
// rtl/ws2812b_pkg.sv - shared types and default timing for the WS2812B pixel encoder
//
// Purpose: holds the encoder state enum, the default WS2812B timing constants
//          (in clock cycles at 64 MHz) and the 24-bit GRB pixel type.
// Ports:   none (package).
// Config:  WS2812B_PIXEL_FIFO_EN selects the 4-entry pixel FIFO in the encoder.

package ws2812b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_e;

  localparam int T0H_DEF   = 26;
  localparam int T1H_DEF   = 51;
  localparam int BIT_DEF   = 80;
  localparam int LATCH_DEF = 5120;

  localparam int PIXEL_BITS = 24;

  // G in [23:16], R in [15:8], B in [7:0]
  typedef logic [PIXEL_BITS-1:0] pixel_t;

endpackage

// File: rtl/ws2812b_pixel_fifo.sv
// rtl/ws2812b_pixel_fifo.sv - 4-entry pixel FIFO used when WS2812B_PIXEL_FIFO_EN is defined
//
// Purpose: first-in first-out store for pixels waiting to be serialised.
//          The module only exists in builds with WS2812B_PIXEL_FIFO_EN defined.
// Ports:   clk, reset     - clock, asynchronous active-high reset
//          push/push_data - write one pixel (caller guarantees !full)
//          pop/pop_data   - remove head pixel; pop_data shows the head
//                           combinationally (caller guarantees !empty)
//          full, empty    - occupancy flags

`ifdef WS2812B_PIXEL_FIFO_EN
module ws2812b_pixel_fifo
  import ws2812b_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  pixel_t push_data,
  input  logic   pop,
  output pixel_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  pixel_t             mem_q [DEPTH];
  pixel_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // push and pop in the same cycle leave the occupancy unchanged
    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule
`endif

// File: rtl/ws2812b_pixel_encoder.sv
// rtl/ws2812b_pixel_encoder.sv - serialises 24-bit GRB pixels onto a WS2812B data line
//
// Purpose: accepts pixels over a valid/ready handshake and emits each bit MSB
//          first as a high pulse (T1H or T0H cycles) followed by low time up to
//          BIT_CYCLES. When no further pixel is waiting after bit 23, the line
//          is held low for LATCH_CYCLES and frame_done pulses on the last cycle.
// Ports:   clk, reset             - clock, asynchronous active-high reset
//          pix_valid/pix_data     - pixel offer (GRB, G in [23:16])
//          pix_ready              - high while pixel storage has room
//          dout                   - registered serial line
//          busy                   - not IDLE, or a pixel is waiting in storage
//          frame_done             - one-cycle pulse on the final LATCH cycle
// Config:  WS2812B_PIXEL_FIFO_EN defined   -> 4-entry FIFO (ws2812b_pixel_fifo)
//          WS2812B_PIXEL_FIFO_EN undefined -> single holding register

module ws2812b_pixel_encoder
  import ws2812b_pkg::*;
#(
  parameter int CLK_HZ       = 64000000,
  parameter int T0H_CYCLES   = T0H_DEF,
  parameter int T1H_CYCLES   = T1H_DEF,
  parameter int BIT_CYCLES   = BIT_DEF,
  parameter int LATCH_CYCLES = LATCH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_valid,
  input  logic [PIXEL_BITS-1:0] pix_data,
  output logic                  pix_ready,
  output logic                  dout,
  output logic                  busy,
  output logic                  frame_done
);

  if (!(CLK_HZ > 0 && T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
        T1H_CYCLES < BIT_CYCLES && LATCH_CYCLES > 0)) begin : g_bad_params
    $error("ws2812b_pixel_encoder: timing parameters out of range");
  end

  localparam int CNT_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t T0H_LAST   = cnt_t'(T0H_CYCLES - 1);
  localparam cnt_t T1H_LAST   = cnt_t'(T1H_CYCLES - 1);
  localparam cnt_t BIT_LAST   = cnt_t'(BIT_CYCLES - 1);
  localparam cnt_t LATCH_LAST = cnt_t'(LATCH_CYCLES - 1);

  logic   accept;
  logic   load;
  logic   stored;
  pixel_t stored_pix;

  assign accept = pix_valid & pix_ready;

  // ---------------------------------------------------------------- storage
`ifdef WS2812B_PIXEL_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  ws2812b_pixel_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (pix_data),
    .pop       (load),
    .pop_data  (stored_pix),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pix_ready = ~fifo_full;
  assign stored    = ~fifo_empty;
`else
  pixel_t hold_q, hold_d;
  logic   hold_valid_q, hold_valid_d;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_d       = pix_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign pix_ready  = ~hold_valid_q;
  assign stored     = hold_valid_q;
  assign stored_pix = hold_q;
`endif

  // -------------------------------------------------------------- serialiser
  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  pixel_t     shift_q, shift_d;
  logic [4:0] bit_idx_q, bit_idx_d;
  logic       dout_q, dout_d;
  logic       frame_done_q, frame_done_d;
  cnt_t       high_last;

  // One counter spans the whole bit: HIGH runs 0..high_last, LOW carries on
  // to BIT_LAST, so the bit period is fixed regardless of the bit value.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    load      = 1'b0;
    high_last = shift_q[PIXEL_BITS-1] ? T1H_LAST : T0H_LAST;

    case (state_q)
      ST_IDLE: begin
        if (stored) begin
          load      = 1'b1;
          shift_d   = stored_pix;
          bit_idx_d = '0;
          cnt_d     = '0;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == high_last) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q != 5'(PIXEL_BITS - 1)) begin
            shift_d   = {shift_q[PIXEL_BITS-2:0], 1'b0};
            bit_idx_d = bit_idx_q + 5'd1;
            state_d   = ST_HIGH;
          end else if (stored) begin
            // next pixel follows with no gap cycle
            load      = 1'b1;
            shift_d   = stored_pix;
            bit_idx_d = '0;
            state_d   = ST_HIGH;
          end else begin
            state_d = ST_LATCH;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // outputs are decoded from the next state so the flops line up with it
    dout_d       = (state_d == ST_HIGH);
    frame_done_d = (state_d == ST_LATCH) && (cnt_d == LATCH_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout       = dout_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE) || stored;

endmodule

// File: tb/tb_ws2812b_pixel_encoder.sv
// tb/tb_ws2812b_pixel_encoder.sv - scoreboard bench for ws2812b_pixel_encoder
//
// Purpose: drives pixels over valid/ready, decodes dout back into pixels in an
//          independent monitor and compares them against the queue of accepted
//          pixels, together with bit timing, latch timing and reset behaviour.
// Ports:   none (top-level bench).
// Config:  WS2812B_PIXEL_FIFO_EN selects the expected storage depth.

module tb_ws2812b_pixel_encoder;

  localparam int T0H   = 26;
  localparam int T1H   = 51;
  localparam int BITC  = 80;
  localparam int LATCH = 5120;
`ifdef WS2812B_PIXEL_FIFO_EN
  localparam int STORE_DEPTH = 4;
`else
  localparam int STORE_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  ws2812b_pixel_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  logic [23:0] exp_q[$];
  int          acc_cycles[$];

  int          rises = 0;
  int          frames = 0;
  int          pixels_seen = 0;
  int          nbits = 0;
  int          hi_len = 0;
  int          last_rise = 0;
  int          last_fd = 0;
  int          rise_after_fd = -1;
  bit          have_rise = 0;
  bit          fd_since = 0;
  bit          prev_dout = 0;
  logic [23:0] acc = '0;

  always @(negedge clk) begin
    if (reset) begin
      have_rise = 0;
      fd_since  = 0;
      prev_dout = 0;
      nbits     = 0;
      hi_len    = 0;
    end else begin
      if (dout && !prev_dout) begin
        if (have_rise && !fd_since) begin
          check("bit_period", cyc - last_rise, BITC);
        end else if (have_rise) begin
          check("rise_after_frame_done", (cyc - last_fd) >= 1, 1);
          rise_after_fd = cyc - last_fd;
        end
        rises++;
        last_rise = cyc;
        have_rise = 1;
        fd_since  = 0;
        hi_len    = 0;
      end
      if (dout) hi_len++;
      if (!dout && prev_dout) begin
        checks++;
        if (hi_len != T0H && hi_len != T1H) begin
          failures++;
          $display("FAIL high_width: got %0d expected %0d or %0d", hi_len, T0H, T1H);
        end
        acc = {acc[22:0], (hi_len == T1H)};
        nbits++;
        if (nbits == 24) begin
          nbits = 0;
          pixels_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", acc, 32'hFFFF_FFFF);
          end else begin
            check("pixel_data", acc, exp_q.pop_front());
          end
        end
      end
      if (frame_done) begin
        check("latch_timing", (have_rise && !fd_since) ? (cyc - last_rise) : -1,
              BITC + LATCH - 1);
        check("frame_bit_align", nbits, 0);
        check("latch_dout_low", dout, 0);
        fd_since = 1;
        last_fd  = cyc;
        frames++;
      end
      prev_dout = dout;
    end
  end

  // --------------------------------------------------------------- drivers
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [23:0] d, input bit keep);
    int n = 0;
    pix_valid = 1'b1;
    while (!pix_ready && n < 20000) begin
      pix_data = $urandom;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20000) check("accept_timeout", 0, 1);
    pix_data = d;
    @(posedge clk); #1;
    exp_q.push_back(d);
    acc_cycles.push_back(cyc);
    if (!keep) begin
      pix_valid = 1'b0;
      pix_data  = $urandom;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      @(posedge clk); #1;
      if (!pix_valid) pix_data = $urandom;
      n++;
    end
    check({name, "_done"}, n < 20000, 1);
    check({name, "_dout_idle"}, dout, 0);
  endtask

  // ----------------------------------------------------------------- tests
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int r0;
    int c0;
    int n_early;
    logic [23:0] p;

    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", pix_ready, 1);
    check("busy_after_reset", busy, 0);

    // all-zero pixel: 24 short pulses, then latch
    f0 = frames;
    send(24'h000000, 0);
    wait_idle("zero");
    check("zero_frames", frames - f0, 1);

    // mixed pixel, then a pixel offered in the middle of its latch
    f0 = frames;
    rise_after_fd = -1;
    acc_cycles.delete();
    send(24'hA5FF00, 0);
    c0 = acc_cycles[0];
    while (cyc < c0 + 1 + 24 * BITC + LATCH / 2) begin
      @(posedge clk); #1;
    end
    check("mid_latch_busy", busy, 1);
    check("mid_latch_no_frame_yet", frames - f0, 0);
    send(24'hFFFFFF, 0);
    wait_idle("latch_accept");
    check("latch_accept_frames", frames - f0, 2);
    check("latch_accept_restart", rise_after_fd, 2);

    // back-to-back pixels share one frame
    f0 = frames;
    send(24'h123456, 1);
    send(24'hABCDEF, 0);
    wait_idle("b2b");
    check("b2b_frames", frames - f0, 1);

    // backpressure with valid held high over six random pixels
    f0 = frames;
    acc_cycles.delete();
    for (int i = 0; i < 6; i++) begin
      p = $urandom;
      send(p, i != 5);
    end
    n_early = 0;
    foreach (acc_cycles[i]) if (acc_cycles[i] - acc_cycles[0] < BITC) n_early++;
    check("backpressure_accepts", n_early, 1 + STORE_DEPTH);
    wait_idle("backpressure");
    check("backpressure_frames", frames - f0, 1);
    check("backpressure_pixels", pixels_seen, 11);

    // two random pixels with a short random gap still join without a latch
    f0 = frames;
    p = $urandom;
    send(p, 0);
    repeat ($urandom_range(0, 30)) begin
      @(posedge clk); #1;
      pix_data = $urandom;
    end
    p = $urandom;
    send(p, 0);
    wait_idle("random_pair");
    check("random_pair_frames", frames - f0, 1);

    // reset at cycle 40 of bit 5 discards the pixel in flight and the stored one
    acc_cycles.delete();
    send(24'hFFFFFF, 1);
    send(24'h0F0F0F, 0);
    c0 = acc_cycles[0];
    while (cyc < c0 + 1 + 5 * BITC + 40) begin
      @(posedge clk); #1;
    end
    #2;
    check("pre_reset_dout", dout, 1);
    reset = 1'b1;
    #1;
    check("async_reset_dout", dout, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_frame_done", frame_done, 0);
    exp_q.delete();
    r0 = rises;
    f0 = frames;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", pix_ready, 1);
    repeat (300) begin
      @(posedge clk); #1;
    end
    check("post_reset_no_pulses", rises - r0, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_no_frame", frames - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812b_pixel_encoder.md
WS2812B_PIXEL_ENCODER -- requirements
Module: ws2812b_pixel_encoder

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 64000000, meaning the clock frequency in Hz (informational only).
REQ-002 The block SHALL have parameter T0H_CYCLES, default 26, meaning the high time of a 0 bit.
REQ-003 The block SHALL have parameter T1H_CYCLES, default 51, meaning the high time of a 1 bit.
REQ-004 The block SHALL have parameter BIT_CYCLES, default 80, meaning the total bit period; the block SHALL require T0H_CYCLES < T1H_CYCLES < BIT_CYCLES.
REQ-005 The block SHALL have parameter LATCH_CYCLES, default 5120, meaning the low time of the end-of-frame latch (80 us).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port pix_valid, input, 1 bit: pixel offered.
REQ-009 The block SHALL have port pix_data, input, 24 bits: GRB pixel, G in [23:16], R in [15:8], B in [7:0].
REQ-010 The block SHALL have port pix_ready, output, 1 bit: pixel accepted when pix_valid and pix_ready are both high on a clk edge.
REQ-011 The block SHALL have port dout, output, 1 bit: WS2812B serial line.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE, or while any pixel is stored.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last cycle of LATCH.

Function
REQ-014 The block SHALL implement the states IDLE, HIGH, LOW and LATCH.
REQ-015 In IDLE with a stored pixel, the block SHALL load the pixel into a 24-bit shift register and enter HIGH on the next edge.
REQ-016 In IDLE with no stored pixel, the block SHALL stay in IDLE with dout low.
REQ-017 The block SHALL transmit bits MSB first (pix_data[23] first).
REQ-018 In HIGH, dout SHALL be 1 for exactly T1H_CYCLES (bit = 1) or T0H_CYCLES (bit = 0), after which the block SHALL enter LOW.
REQ-019 In LOW, dout SHALL be 0 for the remainder of BIT_CYCLES, so each bit occupies exactly BIT_CYCLES cycles.
REQ-020 After LOW of bits 0–22, the block SHALL enter HIGH for the next bit.
REQ-021 After LOW of bit 23 with a pixel stored, the block SHALL load that pixel and enter HIGH with no gap cycle.
REQ-022 After LOW of bit 23 with nothing stored, the block SHALL enter LATCH.
REQ-023 LATCH SHALL hold dout low for exactly LATCH_CYCLES cycles, assert frame_done on the final cycle, and then return to IDLE.
REQ-024 A pixel accepted during LATCH SHALL be stored, and SHALL start transmission only after LATCH completes.
REQ-025 pix_ready SHALL be combinationally high iff storage is not full; an accept and a load in the same cycle SHALL both take effect.
REQ-026 pix_data SHALL be captured only on accept; changes to pix_data while pix_valid is low or pix_ready is low SHALL be ignored.
REQ-027 The cycle counter SHALL be sized as $clog2(max(BIT_CYCLES, LATCH_CYCLES)+1) bits and SHALL never wrap within a state.
REQ-028 dout SHALL be driven directly from a register, with no combinational glitches.

Reset
REQ-029 On assertion of reset, the block SHALL asynchronously enter the reset state: state IDLE, dout 0, busy 0, frame_done 0, counters 0, storage empty.
REQ-030 Reset asserted mid-bit or mid-latch SHALL abort immediately, and the pixel in flight and all stored pixels SHALL be discarded.
REQ-031 After reset is released, pix_ready SHALL be 1.

Configuration
REQ-032 When macro WS2812B_PIXEL_FIFO_EN is defined, pixel storage SHALL be a 4-entry FIFO, and pix_ready SHALL be low only when all 4 entries are occupied.
REQ-033 When WS2812B_PIXEL_FIFO_EN is undefined, storage SHALL be a single holding register, and pix_ready SHALL be low while that register is full; the shift register SHALL NOT count as storage.

Structure
REQ-034 Package ws2812b_pkg SHALL hold the state enum, the default timing constants (T0H, T1H, BIT, LATCH), and the 24-bit pixel typedef.
REQ-035 The FIFO SHALL be implemented as sub-module ws2812b_pixel_fifo, instantiated only under WS2812B_PIXEL_FIFO_EN.

Verification
REQ-036 Scenario (zero pixel): accept 0x000000 -> 24 pulses of 26 high / 54 low, then 5120 low, then a frame_done pulse, then IDLE.
REQ-037 Scenario (mixed pixel): accept 0xA5FF00 -> decoded bit sequence 10100101 11111111 00000000, with the period of every bit exactly 80 cycles.
REQ-038 Scenario (back-to-back): offer 0x123456 and 0xABCDEF back to back -> no gap between bit 23 of the first pixel and bit 0 of the second, and a single LATCH at the end.
REQ-039 Scenario (backpressure): hold pix_valid high with 6 pixels -> pix_ready drops after 1+4 accepts (FIFO build) or 1+1 accepts (no FIFO), and all pixels are sent in order.
REQ-040 Scenario (reset mid-operation): reset at cycle 40 of bit 5 -> dout is 0 asynchronously, busy is 0, and no further pulses appear.
REQ-041 Scenario (accept during latch): accept 0xFFFFFF in the middle of LATCH -> the first high pulse starts only after the frame_done cycle.
